// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multi-cycle MIPS controller.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
package mc_ctrl_pkg;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEMACC = 3'd3,
      S_WBACK  = 3'd4,
      S_TRAP   = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEMACC = 3'd3,
      S_WBACK  = 3'd4
   } state_e;
`endif

   typedef enum logic [2:0] {
      C_RTYPE = 3'd0,
      C_IMM   = 3'd1,
      C_LW    = 3'd2,
      C_SW    = 3'd3,
      C_BEQ   = 3'd4,
      C_J     = 3'd5,
      C_BAD   = 3'd6
   } iclass_e;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // Static datapath controls produced by the decoder
   typedef struct packed {
      logic       ext_op;
      logic [2:0] alu_ctr;
      logic       alu_src;
      logic       reg_dst;
      logic       mem_to_reg;
   } dec_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational op/func decoder -> instruction class and static
// datapath control fields. Unsupported encodings map to C_BAD with all-zero fields.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] func_i,
   output iclass_e    cls_o,
   output dec_t       ctl_o
);

   // Classify the instruction and derive its static controls
   always_comb begin
      cls_o = C_BAD;
      ctl_o = '0;
      unique case (op_i)
         OP_RTYPE: begin
            cls_o         = C_RTYPE;
            ctl_o.reg_dst = 1'b1;
            unique case (func_i)
               FN_ADDU: ctl_o.alu_ctr = ALU_ADD;
               FN_SUBU: ctl_o.alu_ctr = ALU_SUB;
               FN_AND:  ctl_o.alu_ctr = ALU_AND;
               FN_OR:   ctl_o.alu_ctr = ALU_OR;
               FN_SLT:  ctl_o.alu_ctr = ALU_SLT;
               default: begin
                  cls_o = C_BAD;
                  ctl_o = '0;
               end
            endcase
         end
         OP_ORI: begin
            cls_o         = C_IMM;
            ctl_o.alu_ctr = ALU_OR;
            ctl_o.alu_src = 1'b1;
         end
         OP_ADDIU: begin
            cls_o         = C_IMM;
            ctl_o.ext_op  = 1'b1;
            ctl_o.alu_ctr = ALU_ADD;
            ctl_o.alu_src = 1'b1;
         end
         OP_LW: begin
            cls_o            = C_LW;
            ctl_o.ext_op     = 1'b1;
            ctl_o.alu_ctr    = ALU_ADD;
            ctl_o.alu_src    = 1'b1;
            ctl_o.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            cls_o         = C_SW;
            ctl_o.ext_op  = 1'b1;
            ctl_o.alu_ctr = ALU_ADD;
            ctl_o.alu_src = 1'b1;
         end
         OP_BEQ: begin
            cls_o         = C_BEQ;
            ctl_o.ext_op  = 1'b1;
            ctl_o.alu_ctr = ALU_SUB;
         end
         OP_J: begin
            cls_o = C_J;
         end
         default: begin
            cls_o = C_BAD;
            ctl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
// FETCH/DECODE/EXEC/MEMACC/WBACK sequencing with a mem_ready stall handshake.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (unsupported encodings trap
// in TRAP with illegal=1 until reset; otherwise they retire as a NOP).
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       mem_ready,
   output logic       IRWr,
   output logic       PCWr,
   output logic       RegWr,
   output logic       MemWr,
   output logic       ExtOp,
   output logic       ALUsrc,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       branch,
   output logic       jump,
   output logic [2:0] ALUctr,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       illegal
);

   state_e  state_q, state_d;
   iclass_e cls_q;
   dec_t    dec_q;
   iclass_e cls_w;
   dec_t    dec_w;

   mc_decode u_decode (
      .op_i   (op),
      .func_i (func),
      .cls_o  (cls_w),
      .ctl_o  (dec_w)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Decode registers: capture class and static controls at the end of DECODE
   always_ff @(posedge clk) begin
      if (rst) begin
         cls_q <= C_RTYPE;
         dec_q <= '0;
      end else if (state_q == S_DECODE) begin
         cls_q <= cls_w;
         dec_q <= dec_w;
      end
   end

   // Next-state and write-enable generation; DECODE uses the live decode,
   // later states use the registered class
   always_comb begin
      state_d    = state_q;
      IRWr       = 1'b0;
      PCWr       = 1'b0;
      RegWr      = 1'b0;
      MemWr      = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      instr_done = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            IRWr = 1'b1;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (cls_w == C_J) begin
               jump       = 1'b1;
               PCWr       = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (cls_w == C_BAD) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               state_d    = S_TRAP;
`else
               PCWr       = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cls_q == C_BEQ) begin
               branch     = 1'b1;
               PCWr       = 1'b1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (cls_q == C_LW || cls_q == C_SW) begin
               state_d = S_MEMACC;
            end else begin
               state_d = S_WBACK;
            end
         end
         S_MEMACC: begin
            if (cls_q == C_SW) begin
               MemWr = 1'b1;
               if (mem_ready) begin
                  PCWr       = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            end else if (mem_ready) begin
               state_d = S_WBACK;
            end
         end
         S_WBACK: begin
            RegWr      = 1'b1;
            PCWr       = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         S_TRAP: begin
            state_d = S_TRAP;
         end
`endif
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   assign illegal = (state_q == S_TRAP);
`else
   assign illegal = 1'b0;
`endif

   assign state    = state_q;
   assign ExtOp    = dec_q.ext_op;
   assign ALUctr   = dec_q.alu_ctr;
   assign ALUsrc   = dec_q.alu_src;
   assign RegDst   = dec_q.reg_dst;
   assign MemtoReg = dec_q.mem_to_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven per-cycle bench for mc_ctrl.
// Each row gives the inputs for one cycle and the outputs expected in that
// cycle. Honours MC_CTRL_ILLEGAL_TRAP_EN for the unsupported-opcode rows.
module tb_mc_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] op;
   logic [5:0] func;
   logic       mem_ready;
   logic       IRWr, PCWr, RegWr, MemWr, ExtOp, ALUsrc, RegDst, MemtoReg;
   logic       branch, jump, instr_done, illegal;
   logic [2:0] ALUctr, state;

   mc_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .func       (func),
      .mem_ready  (mem_ready),
      .IRWr       (IRWr),
      .PCWr       (PCWr),
      .RegWr      (RegWr),
      .MemWr      (MemWr),
      .ExtOp      (ExtOp),
      .ALUsrc     (ALUsrc),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .branch     (branch),
      .jump       (jump),
      .ALUctr     (ALUctr),
      .state      (state),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Opcodes / funcs
   localparam logic [5:0] R   = 6'b000000;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] J   = 6'b000010;
   localparam logic [5:0] ORI = 6'b001101;
   localparam logic [5:0] ADI = 6'b001001;
   localparam logic [5:0] BAD = 6'b111111;
   localparam logic [5:0] FADDU = 6'b100001;
   localparam logic [5:0] FSUBU = 6'b100011;
   localparam logic [5:0] FAND  = 6'b100100;
   localparam logic [5:0] FOR   = 6'b100101;
   localparam logic [5:0] FSLT  = 6'b101010;

   // ctl = {IRWr,PCWr,RegWr,MemWr,branch,jump,instr_done,illegal}
   localparam logic [7:0] C_FET  = 8'b1000_0000;
   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_WB   = 8'b0110_0010;
   localparam logic [7:0] C_SWW  = 8'b0001_0000;
   localparam logic [7:0] C_SWD  = 8'b0101_0010;
   localparam logic [7:0] C_BEQ  = 8'b0100_1010;
   localparam logic [7:0] C_J    = 8'b0100_0110;
   localparam logic [7:0] C_NOP  = 8'b0100_0010;
   localparam logic [7:0] C_TRAP = 8'b0000_0001;

   // dr = {ExtOp,ALUsrc,RegDst,MemtoReg,ALUctr[2:0]}
   localparam logic [6:0] D_ZERO = 7'b0000_000;
   localparam logic [6:0] D_ADDU = 7'b0010_000;
   localparam logic [6:0] D_SUBU = 7'b0010_001;
   localparam logic [6:0] D_AND  = 7'b0010_010;
   localparam logic [6:0] D_OR   = 7'b0010_011;
   localparam logic [6:0] D_SLT  = 7'b0010_100;
   localparam logic [6:0] D_LW   = 7'b1101_000;
   localparam logic [6:0] D_SW   = 7'b1100_000;
   localparam logic [6:0] D_BEQ  = 7'b1000_001;
   localparam logic [6:0] D_ORI  = 7'b0100_011;
   localparam logic [6:0] D_ADI  = 7'b1100_000;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] func;
      logic       rdy;
      logic [2:0] st;
      logic [7:0] ctl;
      logic [6:0] dr;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(input logic r, input logic [5:0] o, input logic [5:0] f,
                               input logic rd, input logic [2:0] s,
                               input logic [7:0] c, input logic [6:0] d);
      vec_t v;
      v.rst = r; v.op = o; v.func = f; v.rdy = rd; v.st = s; v.ctl = c; v.dr = d;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int row, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
      end
   endtask

   function automatic logic [7:0] ctl_act();
      return {IRWr, PCWr, RegWr, MemWr, branch, jump, instr_done, illegal};
   endfunction

   function automatic logic [6:0] dr_act();
      return {ExtOp, ALUsrc, RegDst, MemtoReg, ALUctr};
   endfunction

   initial begin
      // addu, op changed during EXEC/WBACK must be ignored
      add(0, R,   FADDU, 1, 0, C_FET,  D_ZERO);
      add(0, R,   FADDU, 1, 1, C_NONE, D_ZERO);
      add(0, LW,  6'd0,  1, 2, C_NONE, D_ADDU);
      add(0, SW,  6'd0,  1, 4, C_WB,   D_ADDU);
      // lw with two not-ready cycles in MEMACC: 7 cycles
      add(0, LW,  6'd0,  1, 0, C_FET,  D_ADDU);
      add(0, LW,  6'd0,  1, 1, C_NONE, D_ADDU);
      add(0, LW,  6'd0,  1, 2, C_NONE, D_LW);
      add(0, LW,  6'd0,  0, 3, C_NONE, D_LW);
      add(0, LW,  6'd0,  0, 3, C_NONE, D_LW);
      add(0, LW,  6'd0,  1, 3, C_NONE, D_LW);
      add(0, LW,  6'd0,  1, 4, C_WB,   D_LW);
      // sw with a fetch stall and a store stall
      add(0, SW,  6'd0,  0, 0, C_FET,  D_LW);
      add(0, SW,  6'd0,  1, 0, C_FET,  D_LW);
      add(0, SW,  6'd0,  1, 1, C_NONE, D_LW);
      add(0, SW,  6'd0,  1, 2, C_NONE, D_SW);
      add(0, SW,  6'd0,  0, 3, C_SWW,  D_SW);
      add(0, SW,  6'd0,  1, 3, C_SWD,  D_SW);
      // beq
      add(0, BEQ, 6'd0,  1, 0, C_FET,  D_SW);
      add(0, BEQ, 6'd0,  1, 1, C_NONE, D_SW);
      add(0, BEQ, 6'd0,  1, 2, C_BEQ,  D_BEQ);
      // j
      add(0, J,   6'd0,  1, 0, C_FET,  D_BEQ);
      add(0, J,   6'd0,  1, 1, C_J,    D_BEQ);
      // ori aborted by reset in EXEC
      add(0, ORI, 6'd0,  1, 0, C_FET,  D_ZERO);
      add(0, ORI, 6'd0,  1, 1, C_NONE, D_ZERO);
      add(1, ORI, 6'd0,  1, 2, C_NONE, D_ORI);
      add(0, ORI, 6'd0,  0, 0, C_FET,  D_ZERO);
      // addiu
      add(0, ADI, 6'd0,  1, 0, C_FET,  D_ZERO);
      add(0, ADI, 6'd0,  1, 1, C_NONE, D_ZERO);
      add(0, ADI, 6'd0,  1, 2, C_NONE, D_ADI);
      add(0, ADI, 6'd0,  1, 4, C_WB,   D_ADI);
      // subu, and, or, slt
      add(0, R,   FSUBU, 1, 0, C_FET,  D_ADI);
      add(0, R,   FSUBU, 1, 1, C_NONE, D_ADI);
      add(0, R,   FSUBU, 1, 2, C_NONE, D_SUBU);
      add(0, R,   FSUBU, 1, 4, C_WB,   D_SUBU);
      add(0, R,   FAND,  1, 0, C_FET,  D_SUBU);
      add(0, R,   FAND,  1, 1, C_NONE, D_SUBU);
      add(0, R,   FAND,  1, 2, C_NONE, D_AND);
      add(0, R,   FAND,  1, 4, C_WB,   D_AND);
      add(0, R,   FOR,   1, 0, C_FET,  D_AND);
      add(0, R,   FOR,   1, 1, C_NONE, D_AND);
      add(0, R,   FOR,   1, 2, C_NONE, D_OR);
      add(0, R,   FOR,   1, 4, C_WB,   D_OR);
      add(0, R,   FSLT,  1, 0, C_FET,  D_OR);
      add(0, R,   FSLT,  1, 1, C_NONE, D_OR);
      add(0, R,   FSLT,  1, 2, C_NONE, D_SLT);
      add(0, R,   FSLT,  1, 4, C_WB,   D_SLT);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      // unsupported opcode traps until reset
      add(0, BAD, 6'd0,  1, 0, C_FET,  D_SLT);
      add(0, BAD, 6'd0,  1, 1, C_NONE, D_SLT);
      add(0, BAD, 6'd0,  1, 5, C_TRAP, D_ZERO);
      add(0, R,   FADDU, 1, 5, C_TRAP, D_ZERO);
      add(1, R,   FADDU, 1, 5, C_TRAP, D_ZERO);
      add(0, R,   FADDU, 0, 0, C_FET,  D_ZERO);
`else
      // unsupported R-type func and opcode retire as NOPs in DECODE
      add(0, R,   6'd0,  1, 0, C_FET,  D_SLT);
      add(0, R,   6'd0,  1, 1, C_NOP,  D_SLT);
      add(0, BAD, 6'd0,  1, 0, C_FET,  D_ZERO);
      add(0, BAD, 6'd0,  1, 1, C_NOP,  D_ZERO);
      add(0, R,   FADDU, 0, 0, C_FET,  D_ZERO);
`endif

      // Reset with op = 000000
      rst = 1'b1; op = R; func = 6'd0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_state", -1, {5'd0, state}, 8'd0);
      check("reset_ctl",   -1, ctl_act(), C_FET);
      check("reset_dr",    -1, {1'b0, dr_act()}, 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; op = vecs[i].op; func = vecs[i].func; mem_ready = vecs[i].rdy;
         #1;
         check("state", i, {5'd0, state}, {5'd0, vecs[i].st});
         check("ctl",   i, ctl_act(), vecs[i].ctl);
         check("dr",    i, {1'b0, dr_act()}, {1'b0, vecs[i].dr});
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
